// File: rtl/imu_sample_conditioner_if.sv
// Raw IMU beat stream in, conditioned six-axis frame out.
// Master drives raw beats and consumes frames; slave is the conditioner.
interface imu_sample_conditioner_if #(
    parameter int RAW_WIDTH  = 16,
    parameter int ACC_WIDTH  = 11,
    parameter int GYRO_WIDTH = 14
);
    logic                         raw_valid;
    logic                         raw_ready;
    logic [2:0]                   raw_axis;
    logic signed [RAW_WIDTH-1:0]  raw_data;
    logic                         valid_out;
    logic                         ready_out;
    logic signed [ACC_WIDTH-1:0]  a_x;
    logic signed [ACC_WIDTH-1:0]  a_y;
    logic signed [ACC_WIDTH-1:0]  a_z;
    logic signed [GYRO_WIDTH-1:0] w_x;
    logic signed [GYRO_WIDTH-1:0] w_y;
    logic signed [GYRO_WIDTH-1:0] w_z;

    modport master (
        output raw_valid, raw_axis, raw_data, ready_out,
        input  raw_ready, valid_out,
        input  a_x, a_y, a_z, w_x, w_y, w_z
    );

    modport slave (
        input  raw_valid, raw_axis, raw_data, ready_out,
        output raw_ready, valid_out,
        output a_x, a_y, a_z, w_x, w_y, w_z
    );
endinterface

// File: rtl/imu_sample_conditioner.sv
// Per-axis bias/round/saturate, six-axis frame assembly and a
// single-entry output register with drop and sequence-error counters.
module imu_sample_conditioner #(
    parameter int RAW_WIDTH  = 16,
    parameter int ACC_WIDTH  = 11,
    parameter int GYRO_WIDTH = 14,
    parameter int ACC_SHIFT  = 5,
    parameter int GYRO_SHIFT = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    imu_sample_conditioner_if.slave     io,
    input  logic signed [RAW_WIDTH-1:0] gyro_bias_x,
    input  logic signed [RAW_WIDTH-1:0] gyro_bias_y,
    input  logic signed [RAW_WIDTH-1:0] gyro_bias_z,
    output logic [CNT_WIDTH-1:0]        drop_cnt,
    output logic [CNT_WIDTH-1:0]        err_cnt
);
    localparam int AW = RAW_WIDTH + 1;
    localparam int GW = RAW_WIDTH + 2;

    localparam logic signed [AW-1:0] ACC_RND =
        AW'(2 ** (ACC_SHIFT - 1));
    localparam logic signed [AW-1:0] ACC_MAX =
        AW'(2 ** (ACC_WIDTH - 1) - 1);
    localparam logic signed [AW-1:0] ACC_MIN =
        AW'(-(2 ** (ACC_WIDTH - 1)));
    localparam logic signed [GW-1:0] GYRO_RND =
        GW'(2 ** (GYRO_SHIFT - 1));
    localparam logic signed [GW-1:0] GYRO_MAX =
        GW'(2 ** (GYRO_WIDTH - 1) - 1);
    localparam logic signed [GW-1:0] GYRO_MIN =
        GW'(-(2 ** (GYRO_WIDTH - 1)));

    logic signed [RAW_WIDTH-1:0]  bias;
    logic signed [AW-1:0]         acc_t;
    logic signed [AW-1:0]         acc_s;
    logic signed [AW-1:0]         gyro_d;
    logic signed [GW-1:0]         gyro_t;
    logic signed [GW-1:0]         gyro_s;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [GYRO_WIDTH-1:0] gyro_q;

    always_comb begin
        case (io.raw_axis)
            3'd3:    bias = gyro_bias_x;
            3'd4:    bias = gyro_bias_y;
            default: bias = gyro_bias_z;
        endcase
        acc_t = AW'(io.raw_data) + ACC_RND;
        acc_s = acc_t >>> ACC_SHIFT;
        if (acc_s > ACC_MAX)
            acc_q = ACC_MAX[ACC_WIDTH-1:0];
        else if (acc_s < ACC_MIN)
            acc_q = ACC_MIN[ACC_WIDTH-1:0];
        else
            acc_q = acc_s[ACC_WIDTH-1:0];
        gyro_d = AW'(io.raw_data) - AW'(bias);
        gyro_t = GW'(gyro_d) + GYRO_RND;
        gyro_s = gyro_t >>> GYRO_SHIFT;
        if (gyro_s > GYRO_MAX)
            gyro_q = GYRO_MAX[GYRO_WIDTH-1:0];
        else if (gyro_s < GYRO_MIN)
            gyro_q = GYRO_MIN[GYRO_WIDTH-1:0];
        else
            gyro_q = gyro_s[GYRO_WIDTH-1:0];
    end

    logic [2:0] exp_axis;
    logic       beat;
    logic       hit;
    logic       err;
    logic       restart;
    logic       frame_done;
    logic       out_free;
    logic       load;
    logic       drop;

    assign io.raw_ready = !rst;
    assign beat       = io.raw_valid && io.raw_ready;
    assign hit        = beat && (io.raw_axis == exp_axis);
    assign err        = beat && !hit;
    assign restart    = err && (io.raw_axis == 3'd0);
    assign frame_done = hit && (exp_axis == 3'd5);
    assign out_free   = !io.valid_out || io.ready_out;
    assign load       = frame_done && out_free;
    assign drop       = frame_done && !out_free;

    logic signed [ACC_WIDTH-1:0]  asm_ax;
    logic signed [ACC_WIDTH-1:0]  asm_ay;
    logic signed [ACC_WIDTH-1:0]  asm_az;
    logic signed [GYRO_WIDTH-1:0] asm_wx;
    logic signed [GYRO_WIDTH-1:0] asm_wy;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_axis     <= '0;
            asm_ax       <= '0;
            asm_ay       <= '0;
            asm_az       <= '0;
            asm_wx       <= '0;
            asm_wy       <= '0;
            err_cnt      <= '0;
            drop_cnt     <= '0;
            io.valid_out <= 1'b0;
            io.a_x       <= '0;
            io.a_y       <= '0;
            io.a_z       <= '0;
            io.w_x       <= '0;
            io.w_y       <= '0;
            io.w_z       <= '0;
        end else begin
            if (hit || restart) begin
                case (io.raw_axis)
                    3'd0:    asm_ax <= acc_q;
                    3'd1:    asm_ay <= acc_q;
                    3'd2:    asm_az <= acc_q;
                    3'd3:    asm_wx <= gyro_q;
                    3'd4:    asm_wy <= gyro_q;
                    default: ;
                endcase
            end
            if (hit)
                exp_axis <= (exp_axis == 3'd5) ? 3'd0 : exp_axis + 3'd1;
            else if (restart)
                exp_axis <= 3'd1;
            else if (err)
                exp_axis <= 3'd0;

            if (err && err_cnt != '1)
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);

            // w_z is the closing beat, so it comes straight from the converter
            if (load) begin
                io.valid_out <= 1'b1;
                io.a_x       <= asm_ax;
                io.a_y       <= asm_ay;
                io.a_z       <= asm_az;
                io.w_x       <= asm_wx;
                io.w_y       <= asm_wy;
                io.w_z       <= gyro_q;
            end else if (io.valid_out && io.ready_out) begin
                io.valid_out <= 1'b0;
            end
        end
    end
endmodule
